// File: rtl/mem_arbiter_rv32_pkg.sv
// Shared encodings for the RV32 data-memory arbiter: FSM states, requester IDs
// and read/write polarity (matches the cache iRW convention).
package mem_arbiter_rv32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/arb_pick_rv32.sv
// Combinational winner select between fetch (I) and load/store (D) requests.
// RR_EN selects round-robin on last winner; otherwise D priority with starvation override.
module arb_pick_rv32
  import mem_arbiter_rv32_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic reqi_i,
  input  logic reqd_i,
  input  logic starve_hit_i,
  input  logic last_win_i,
  output logic grant_o,
  output logic grant_id_o
);

  always_comb begin
    grant_o    = reqi_i | reqd_i;
    grant_id_o = reqd_i ? REQ_D : REQ_I;
    if (reqi_i && reqd_i) begin
      if (RR_EN) begin
        grant_id_o = (last_win_i == REQ_I) ? REQ_D : REQ_I;
      end else begin
        grant_id_o = starve_hit_i ? REQ_I : REQ_D;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rv32.sv
// Serialises fetch and load/store accesses onto the single data-memory port.
// Define ARB_RR_EN for round-robin arbitration; default is D priority with a MAXWAIT starvation guard.
module mem_arbiter_rv32
  import mem_arbiter_rv32_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LAT     = 1,
  parameter int MAXWAIT = 4
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iReqI,
  input  logic [ADDR_W-1:0] iAddrI,
  output logic [31:0]       oRdataI,
  output logic              oValidI,
  output logic              oStallI,
  input  logic              iReqD,
  input  logic              iRWD,
  input  logic [ADDR_W-1:0] iAddrD,
  input  logic [31:0]       iWdataD,
  output logic [31:0]       oRdataD,
  output logic              oValidD,
  output logic              oStallD,
  output logic              oMEM,
  output logic              oRW,
  output logic [ADDR_W-1:0] oMEMADDR,
  output logic [31:0]       oMEMWDATA,
  input  logic [31:0]       iMEMRDATA
);

  localparam logic [1:0] LAT_M1 = 2'(LAT - 1);

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_i_q, rdata_i_d;
  logic [31:0]       rdata_d_q, rdata_d_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              grant, grant_id, starve_hit, last_win;
  logic              arb_now;

  assign arb_now = (state_q == IDLE) && grant;

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic last_q, last_d;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) last_q <= REQ_I;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (arb_now) last_d = grant_id;
  end

  assign last_win   = last_q;
  assign starve_hit = 1'b0;
`else
  localparam bit RR_EN = 1'b0;
  localparam int SW    = $clog2(MAXWAIT + 2);
  logic [SW-1:0] starve_q, starve_d;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  // Only D grants that overtake a waiting fetch count toward forcing I through.
  always_comb begin
    starve_d = starve_q;
    if (arb_now) begin
      if (grant_id == REQ_I) starve_d = '0;
      else if (iReqI)        starve_d = starve_q + 1'b1;
    end
  end

  assign starve_hit = (starve_q == SW'(MAXWAIT));
  assign last_win   = REQ_I;
`endif

  arb_pick_rv32 #(.RR_EN(RR_EN)) u_pick (
    .reqi_i       (iReqI),
    .reqd_i       (iReqD),
    .starve_hit_i (starve_hit),
    .last_win_i   (last_win),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_i_d = rdata_i_q;
    rdata_d_d = rdata_d_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          win_d   = grant_id;
          rw_d    = (grant_id == REQ_D) ? iRWD : RD;
          addr_d  = (grant_id == REQ_D) ? iAddrD : iAddrI;
          wdata_d = (grant_id == REQ_D) ? iWdataD : wdata_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_q == WR) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          if (win_q == REQ_D) rdata_d_d = iMEMRDATA;
          else                rdata_i_d = iMEMRDATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= IDLE;
      win_q     <= REQ_I;
      rw_q      <= RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_i_q <= rdata_i_d;
      rdata_d_q <= rdata_d_d;
    end
  end

  assign oMEM      = (state_q == ISSUE);
  assign oRW       = rw_q;
  assign oMEMADDR  = addr_q;
  assign oMEMWDATA = wdata_q;
  assign oRdataI   = rdata_i_q;
  assign oRdataD   = rdata_d_q;
  assign oValidI   = (state_q == RESP) && (win_q == REQ_I);
  assign oValidD   = (state_q == RESP) && (win_q == REQ_D);
  // Stall drops with reset so a frozen pipeline is released while the lost access is retried.
  assign oStallI   = iRSTn & iReqI & ~oValidI;
  assign oStallD   = iRSTn & iReqD & ~oValidD;

endmodule

// File: tb/tb_mem_arbiter_rv32.sv
// Scoreboard bench for mem_arbiter_rv32: drivers push expected completions, a negedge monitor
// checks every oMEM strobe, oValid pulse and stall against a behavioural memory/reference model.
module tb_mem_arbiter_rv32;
  import mem_arbiter_rv32_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int LAT     = 3;
  localparam int MAXWAIT = 4;
  localparam int TIMEOUT = 200;

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic        iReqI, iReqD, iRWD;
  logic [31:0] iAddrI, iAddrD, iWdataD;
  logic [31:0] oRdataI, oRdataD, oMEMADDR, oMEMWDATA, iMEMRDATA;
  logic        oValidI, oStallI, oValidD, oStallD, oMEM, oRW;

  mem_arbiter_rv32 #(.ADDR_W(ADDR_W), .LAT(LAT), .MAXWAIT(MAXWAIT)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn),
    .iReqI(iReqI), .iAddrI(iAddrI), .oRdataI(oRdataI), .oValidI(oValidI), .oStallI(oStallI),
    .iReqD(iReqD), .iRWD(iRWD), .iAddrD(iAddrD), .iWdataD(iWdataD),
    .oRdataD(oRdataD), .oValidD(oValidD), .oStallD(oStallD),
    .oMEM(oMEM), .oRW(oRW), .oMEMADDR(oMEMADDR), .oMEMWDATA(oMEMWDATA), .iMEMRDATA(iMEMRDATA)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          start;
    int          lat;
  } txn_t;

  txn_t        qi[$];
  txn_t        qd[$];
  txn_t        m_e;
  bit          iss_i, iss_d;
  logic        gl[$];
  logic        exp_gl[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [32];

  function automatic logic [31:0] init_val(input int a);
    return (a == 3) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
  endfunction

  always @(posedge iCLK) cyc <= cyc + 1;

  // External memory: LAT-deep read pipeline from the strobe edge, junk on the bus otherwise.
  logic [31:0] mem [32];
  logic [31:0] pd [LAT];
  logic        pv [LAT];
  logic [31:0] junk;
  bit          mem_ready = 1'b0;

  always @(posedge iCLK) begin
    junk <= $urandom;
    if (!mem_ready) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_val(k);
      mem_ready <= 1'b1;
    end else if (oMEM && oRW == WR) begin
      mem[oMEMADDR[4:0]] <= oMEMWDATA;
    end
    pv[0] <= oMEM && (oRW == RD);
    pd[0] <= mem[oMEMADDR[4:0]];
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end

  assign iMEMRDATA = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : junk;

  // Monitor
  always @(negedge iCLK) begin
    if (iRSTn) begin
      if (oMEM) begin
        checks++;
        if (qd.size() > 0 && !iss_d && oMEMADDR == qd[0].addr && oRW == qd[0].rw &&
            (qd[0].rw == RD || oMEMWDATA == qd[0].wdata)) begin
          iss_d = 1'b1;
          gl.push_back(REQ_D);
        end else if (qi.size() > 0 && !iss_i && oMEMADDR == qi[0].addr && oRW == RD) begin
          iss_i = 1'b1;
          gl.push_back(REQ_I);
        end else begin
          errors++;
          $display("FAIL issue: oMEM addr=%h rw=%b wdata=%h matches no pending request", oMEMADDR, oRW, oMEMWDATA);
        end
      end
      if (oValidI) begin
        checks++;
        if (qi.size() == 0 || !iss_i) begin
          errors++;
          $display("FAIL valid_i: unexpected oValidI (pending=%0d issued=%0b)", qi.size(), iss_i);
        end else begin
          m_e = qi.pop_front();
          iss_i = 1'b0;
          if (oRdataI !== m_e.rdata || (m_e.lat >= 0 && cyc - m_e.start != m_e.lat)) begin
            errors++;
            $display("FAIL rdata_i: addr=%h got data=%h lat=%0d, expected data=%h lat=%0d",
                     m_e.addr, oRdataI, cyc - m_e.start, m_e.rdata, m_e.lat);
          end else begin
            $display("txn I rd addr=%h data=%h lat=%0d", m_e.addr, oRdataI, cyc - m_e.start);
          end
        end
      end
      if (oValidD) begin
        checks++;
        if (qd.size() == 0 || !iss_d) begin
          errors++;
          $display("FAIL valid_d: unexpected oValidD (pending=%0d issued=%0b)", qd.size(), iss_d);
        end else begin
          m_e = qd.pop_front();
          iss_d = 1'b0;
          if ((m_e.rw == RD && oRdataD !== m_e.rdata) || (m_e.lat >= 0 && cyc - m_e.start != m_e.lat)) begin
            errors++;
            $display("FAIL rdata_d: addr=%h rw=%b got data=%h lat=%0d, expected data=%h lat=%0d",
                     m_e.addr, m_e.rw, oRdataD, cyc - m_e.start, m_e.rdata, m_e.lat);
          end else begin
            $display("txn D %s addr=%h data=%h lat=%0d", (m_e.rw == RD) ? "rd" : "wr", m_e.addr,
                     (m_e.rw == RD) ? oRdataD : m_e.wdata, cyc - m_e.start);
          end
        end
      end
      checks++;
      if (oStallI !== (iReqI && !oValidI) || oStallD !== (iReqD && !oValidD)) begin
        errors++;
        $display("FAIL stall: got I=%b D=%b, expected I=%b D=%b", oStallI, oStallD,
                 iReqI && !oValidI, iReqD && !oValidD);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic push_i(input logic [31:0] a, input bit lat_chk);
    txn_t e;
    e.rw = RD; e.addr = a; e.wdata = '0; e.rdata = ref_mem[a[4:0]];
    e.start = cyc; e.lat = lat_chk ? LAT + 2 : -1;
    qi.push_back(e);
  endtask

  task automatic push_d(input logic rw, input logic [31:0] a, input logic [31:0] wd, input bit lat_chk);
    txn_t e;
    e.rw = rw; e.addr = a; e.wdata = wd; e.rdata = ref_mem[a[4:0]];
    e.start = cyc; e.lat = lat_chk ? ((rw == RD) ? LAT + 2 : 2) : -1;
    if (rw == WR) ref_mem[a[4:0]] = wd;
    qd.push_back(e);
  endtask

  // Lone (lat_chk) requests scramble their inputs once granted to show they are registered.
  task automatic drive_i(input logic [31:0] a, input bit lat_chk);
    int n;
    push_i(a, lat_chk);
    iAddrI = a;
    iReqI  = 1'b1;
    n = 0;
    while (n < TIMEOUT) begin
      @(negedge iCLK);
      if (oValidI) break;
      if (lat_chk && n == 1) iAddrI = $urandom;
      n++;
    end
    if (n == TIMEOUT) begin
      errors++;
      $display("FAIL timeout_i: addr=%h no oValidI within %0d cycles", a, TIMEOUT);
    end
    @(posedge iCLK);
    #1;
    iReqI = 1'b0;
  endtask

  task automatic drive_d(input logic rw, input logic [31:0] a, input logic [31:0] wd, input bit lat_chk);
    int n;
    push_d(rw, a, wd, lat_chk);
    iRWD    = rw;
    iAddrD  = a;
    iWdataD = wd;
    iReqD   = 1'b1;
    n = 0;
    while (n < TIMEOUT) begin
      @(negedge iCLK);
      if (oValidD) break;
      if (lat_chk && n == 1) begin
        iAddrD = $urandom; iWdataD = $urandom; iRWD = ~rw;
      end
      n++;
    end
    if (n == TIMEOUT) begin
      errors++;
      $display("FAIL timeout_d: addr=%h no oValidD within %0d cycles", a, TIMEOUT);
    end
    @(posedge iCLK);
    #1;
    iReqD = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge iCLK);
    #2 iRSTn = 1'b0;
    qi.delete(); qd.delete(); iss_i = 1'b0; iss_d = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    #2 iRSTn = 1'b1;
    @(posedge iCLK);
    #1;
  endtask

  task automatic drain_d();
    int n;
    n = 0;
    while (qd.size() != 0 && n < TIMEOUT) begin
      @(posedge iCLK);
      n++;
    end
    checks++;
    if (n == TIMEOUT) begin
      errors++;
      $display("FAIL drain_d: %0d D transactions never completed", qd.size());
    end
    #1;
  endtask

  int   nd, ni, run;
  logic last, pick;

  initial begin
    for (int k = 0; k < 32; k++) ref_mem[k] = init_val(k);
    iRSTn = 1'b0; iReqI = 1'b1; iReqD = 1'b1; iRWD = RD;
    iAddrI = '0; iAddrD = '0; iWdataD = '0;
    repeat (3) @(negedge iCLK);
    chk("rst_oMEM",      {31'b0, oMEM},    32'd0);
    chk("rst_oValidI",   {31'b0, oValidI}, 32'd0);
    chk("rst_oValidD",   {31'b0, oValidD}, 32'd0);
    chk("rst_oStallI",   {31'b0, oStallI}, 32'd0);
    chk("rst_oStallD",   {31'b0, oStallD}, 32'd0);
    chk("rst_oRW",       {31'b0, oRW},     32'd1);
    chk("rst_oMEMADDR",  oMEMADDR,         32'd0);
    chk("rst_oMEMWDATA", oMEMWDATA,        32'd0);
    chk("rst_oRdataI",   oRdataI,          32'd0);
    chk("rst_oRdataD",   oRdataD,          32'd0);
    iReqI = 1'b0; iReqD = 1'b0;
    @(negedge iCLK);
    #2 iRSTn = 1'b1;
    @(posedge iCLK);
    #1;

    // Directed lone accesses with latency checks
    drive_i(32'h3, 1'b1);
    idle(2);
    drive_d(WR, 32'h5, 32'h12345678, 1'b1);
    drive_d(RD, 32'h5, 32'h0, 1'b1);
    drive_d(RD, 32'h14, 32'h0, 1'b1);
    drive_i(32'h5, 1'b1);

    // Both held high: grant order against the arbitration policy
    pulse_reset();
    gl.delete();
    fork
      for (int k = 0; k < 2 * MAXWAIT; k++) drive_d(RD, 32'h10 + 32'(k), 32'h0, 1'b0);
      for (int k = 0; k < 2; k++) drive_i(32'h8 + 32'(k), 1'b0);
    join
    nd = 2 * MAXWAIT; ni = 2; run = 0; last = REQ_I;
    exp_gl.delete();
    while (nd > 0 || ni > 0) begin
      if (nd > 0 && ni > 0) begin
`ifdef ARB_RR_EN
        pick = (last == REQ_I) ? REQ_D : REQ_I;
`else
        pick = (run == MAXWAIT) ? REQ_I : REQ_D;
`endif
      end else begin
        pick = (nd > 0) ? REQ_D : REQ_I;
      end
      if (pick == REQ_D) begin
        nd--;
        if (ni > 0) run++;
      end else begin
        ni--;
        run = 0;
      end
      last = pick;
      exp_gl.push_back(pick);
    end
    chk("grant_count", 32'(gl.size()), 32'(exp_gl.size()));
    for (int k = 0; k < exp_gl.size() && k < gl.size(); k++) begin
      chk($sformatf("grant_%0d", k), {31'b0, gl[k]}, {31'b0, exp_gl[k]});
    end

    // Reset during WAIT: outputs drop at once, lost access never completes, retry succeeds
    push_d(RD, 32'h14, 32'h0, 1'b0);
    iRWD = RD; iAddrD = 32'h14; iReqD = 1'b1;
    repeat (3) @(negedge iCLK);
    #2 iRSTn = 1'b0;
    #1;
    chk("wait_rst_oMEM",    {31'b0, oMEM},    32'd0);
    chk("wait_rst_oValidD", {31'b0, oValidD}, 32'd0);
    chk("wait_rst_oStallD", {31'b0, oStallD}, 32'd0);
    qd.delete(); iss_d = 1'b0;
    @(posedge iCLK);
    iReqD = 1'b0;
    @(negedge iCLK);
    #2 iRSTn = 1'b1;
    idle(8);
    drive_d(RD, 32'h14, 32'h0, 1'b1);

    // Requester drops iReqD during WAIT: completion still pulses once, no second strobe
    push_d(RD, 32'h16, 32'h0, 1'b1);
    iRWD = RD; iAddrD = 32'h16; iReqD = 1'b1;
    repeat (3) @(negedge iCLK);
    @(posedge iCLK);
    #1 iReqD = 1'b0;
    drain_d();
    idle(6);
    drive_i(32'h7, 1'b1);

    // Randomised contention
    fork
      for (int k = 0; k < 20; k++) begin
        idle($urandom_range(0, 3));
        drive_i(32'($urandom_range(0, 15)), 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
        idle($urandom_range(0, 3));
        drive_d(1'($urandom_range(0, 1)), 32'h10 | 32'($urandom_range(0, 15)), $urandom, 1'b0);
      end
    join
    idle(4);
    chk("final_pending_i", 32'(qi.size()), 32'd0);
    chk("final_pending_d", 32'(qd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
